// File: rtl/pic8259_pkg.sv
// Shared types and helpers for the 8259A in-service/acknowledge slice.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: FSM state enum, onehot_to_level encoder, ROTATE_RESET constant.
package pic8259_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACK1  = 2'd1,
    ST_WAIT2 = 2'd2,
    ST_ACK2  = 2'd3
  } isc_state_t;

  // Lowest-priority level after reset: IR7 lowest, so IR0 is highest.
  localparam logic [2:0] ROTATE_RESET = 3'd7;

  // One-hot to binary level. The input is expected to carry at most one set bit.
  function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) lvl = lvl | 3'(i);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/in_service_control_if.sv
// CPU-side acknowledge bus of the interrupt controller: INTA strobe in, INT and vector byte out.
// Latency: wires only; all timing lives in the controller.
// Backpressure: none; the CPU paces the handshake through inta_n.
// Ports: inta_n (CPU->PIC, active-low), int_out, vector_out[7:0], vector_drive (PIC->CPU).
// With IN_SERVICE_POLL_EN defined, poll_cmd and poll_read (CPU->PIC) are added.
interface in_service_control_if;
  logic       inta_n;
  logic       int_out;
  logic [7:0] vector_out;
  logic       vector_drive;
`ifdef IN_SERVICE_POLL_EN
  logic       poll_cmd;
  logic       poll_read;
`endif

  // master = CPU side, slave = interrupt controller
  modport master (
    output inta_n,
`ifdef IN_SERVICE_POLL_EN
    output poll_cmd,
    output poll_read,
`endif
    input  int_out,
    input  vector_out,
    input  vector_drive
  );

  modport slave (
    input  inta_n,
`ifdef IN_SERVICE_POLL_EN
    input  poll_cmd,
    input  poll_read,
`endif
    output int_out,
    output vector_out,
    output vector_drive
  );
endinterface

// File: rtl/isr_priority_pick.sv
// Rotated priority search over the in-service register: finds the highest-priority set bit.
// Latency: combinational.
// Backpressure: none.
// Ports: isr[7:0], rotate[2:0] (lowest-priority level) in; highest_onehot[7:0], highest_level[2:0] out.
// Search starts at rotate+1 and wraps; an empty ISR yields highest_onehot = 0.
module isr_priority_pick (
  input  logic [7:0] isr,
  input  logic [2:0] rotate,
  output logic [7:0] highest_onehot,
  output logic [2:0] highest_level
);

  logic [2:0] lvl;

  // Walk from the lowest-priority slot (k=8 -> rotate) toward the highest (k=1 -> rotate+1);
  // later hits overwrite earlier ones, so the highest-priority set bit wins.
  always_comb begin
    highest_onehot = 8'd0;
    highest_level  = 3'd0;
    lvl            = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      lvl = rotate + 3'(k);
      if (isr[lvl]) begin
        highest_onehot = 8'd1 << lvl;
        highest_level  = lvl;
      end
    end
  end

endmodule

// File: rtl/in_service_control.sv
// Acknowledge-side sequencer: owns ISR and rotation, runs the two-pulse INTA handshake, drives the vector.
// Latency: ISR set / clear pulse / state change visible one cycle after the INTA edge; vector one cycle after 2nd fall.
// Backpressure: none; the CPU paces everything via inta_n, EOI strobes are accepted in any state.
// Ports: clock, reset (sync, active-high); interrupt[7:0] from resolver; icw2_vector, auto_eoi, auto_rotate;
//        eoi_cmd/eoi_specific/eoi_rotate/eoi_level; bus (slave modport: inta_n, int_out, vector_out, vector_drive);
//        clear_interrupt_request, in_service_register, highest_level_in_service, priority_rotate to resolver.
// Optional: IN_SERVICE_POLL_EN adds poll_cmd/poll_read on the bus and the poll-read path.
module in_service_control
  import pic8259_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [7:0]           interrupt,
  input  logic [4:0]           icw2_vector,
  input  logic                 auto_eoi,
  input  logic                 auto_rotate,
  input  logic                 eoi_cmd,
  input  logic                 eoi_specific,
  input  logic                 eoi_rotate,
  input  logic [2:0]           eoi_level,
  in_service_control_if.slave  bus,
  output logic [7:0]           clear_interrupt_request,
  output logic [7:0]           in_service_register,
  output logic [7:0]           highest_level_in_service,
  output logic [2:0]           priority_rotate
);

  isc_state_t state;
  logic       inta_q;
  logic [2:0] ack_level;
  logic       spurious;
`ifdef IN_SERVICE_POLL_EN
  logic       poll_armed;
`endif

  logic       inta_fall;
  logic       inta_rise;
  logic [2:0] hlis_level;
  logic       irq_any;
  logic [2:0] irq_level;
  logic       take;
  logic [7:0] set_mask;
  logic [7:0] eoi_mask;
  logic       eoi_rot_vld;
  logic [2:0] eoi_rot_lvl;
  logic [7:0] aeoi_mask;
  logic       aeoi_rot_vld;

  assign inta_fall = inta_q & ~bus.inta_n;
  assign inta_rise = ~inta_q & bus.inta_n;

  isr_priority_pick u_pick (
    .isr            (in_service_register),
    .rotate         (priority_rotate),
    .highest_onehot (highest_level_in_service),
    .highest_level  (hlis_level)
  );

  // No request at acknowledge time is a spurious cycle: level 7, nothing set.
  assign irq_any   = (interrupt != 8'd0);
  assign irq_level = irq_any ? onehot_to_level(interrupt) : 3'd7;

`ifdef IN_SERVICE_POLL_EN
  assign take = (state == ST_IDLE) &&
                (inta_fall || (poll_armed && bus.poll_read));
`else
  assign take = (state == ST_IDLE) && inta_fall;
`endif

  assign set_mask = (take && irq_any) ? interrupt : 8'd0;

  // EOI does nothing on an empty ISR, including rotation.
  always_comb begin
    eoi_mask    = 8'd0;
    eoi_rot_vld = 1'b0;
    eoi_rot_lvl = hlis_level;
    if (eoi_cmd && (in_service_register != 8'd0)) begin
      eoi_rot_lvl = eoi_specific ? eoi_level : hlis_level;
      eoi_mask    = 8'd1 << eoi_rot_lvl;
      eoi_rot_vld = eoi_rotate;
    end
  end

  always_comb begin
    aeoi_mask    = 8'd0;
    aeoi_rot_vld = 1'b0;
    if ((state == ST_ACK2) && inta_rise && auto_eoi && !spurious) begin
      aeoi_mask    = 8'd1 << ack_level;
      aeoi_rot_vld = auto_rotate;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state                   <= ST_IDLE;
      inta_q                  <= 1'b1;
      ack_level               <= 3'd0;
      spurious                <= 1'b0;
      in_service_register     <= 8'd0;
      priority_rotate         <= ROTATE_RESET;
      clear_interrupt_request <= 8'd0;
      bus.int_out             <= 1'b0;
      bus.vector_drive        <= 1'b0;
      bus.vector_out          <= 8'd0;
`ifdef IN_SERVICE_POLL_EN
      poll_armed              <= 1'b0;
`endif
    end else begin
      inta_q                  <= bus.inta_n;
      clear_interrupt_request <= set_mask;
      // EOI/AEOI clears first, then the acknowledge set, so a same-bit set survives.
      in_service_register     <= (in_service_register & ~eoi_mask & ~aeoi_mask) | set_mask;
      if (aeoi_rot_vld)
        priority_rotate <= ack_level;
      else if (eoi_rot_vld)
        priority_rotate <= eoi_rot_lvl;

      bus.int_out      <= 1'b0;
      bus.vector_drive <= 1'b0;
      bus.vector_out   <= 8'd0;

      case (state)
        ST_IDLE: begin
          bus.int_out <= irq_any && !inta_fall;
          if (inta_fall) begin
            ack_level <= irq_level;
            spurious  <= !irq_any;
            state     <= ST_ACK1;
          end
`ifdef IN_SERVICE_POLL_EN
          else if (poll_armed && bus.poll_read) begin
            // Poll read: status byte for one cycle, ISR set as on a first INTA, INT untouched.
            bus.int_out      <= irq_any;
            bus.vector_drive <= 1'b1;
            bus.vector_out   <= {irq_any, 4'b0000, irq_level};
            poll_armed       <= 1'b0;
          end else if (bus.poll_cmd) begin
            poll_armed <= 1'b1;
          end
`endif
        end
        ST_ACK1: begin
          if (inta_rise) state <= ST_WAIT2;
        end
        ST_WAIT2: begin
          if (inta_fall) begin
            state            <= ST_ACK2;
            bus.vector_drive <= 1'b1;
            bus.vector_out   <= {icw2_vector, ack_level};
          end
        end
        ST_ACK2: begin
          if (inta_rise) begin
            state <= ST_IDLE;
          end else begin
            bus.vector_drive <= 1'b1;
            bus.vector_out   <= {icw2_vector, ack_level};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_in_service_control.sv
// Bench for in_service_control: directed handshakes with literal expectations, then random traffic
// checked every cycle against a behavioural model of the acknowledge protocol and ISR rules.
module tb_in_service_control;

  logic       clock;
  logic       reset;
  logic [7:0] interrupt;
  logic [4:0] icw2_vector;
  logic       auto_eoi;
  logic       auto_rotate;
  logic       eoi_cmd;
  logic       eoi_specific;
  logic       eoi_rotate;
  logic [2:0] eoi_level;
  logic [7:0] clear_interrupt_request;
  logic [7:0] in_service_register;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;

  in_service_control_if bus_if ();

  in_service_control dut (
    .clock                    (clock),
    .reset                    (reset),
    .interrupt                (interrupt),
    .icw2_vector              (icw2_vector),
    .auto_eoi                 (auto_eoi),
    .auto_rotate              (auto_rotate),
    .eoi_cmd                  (eoi_cmd),
    .eoi_specific             (eoi_specific),
    .eoi_rotate               (eoi_rotate),
    .eoi_level                (eoi_level),
    .bus                      (bus_if),
    .clear_interrupt_request  (clear_interrupt_request),
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Handshake progress is tracked as the number of INTA edges seen (fall, rise, fall, rise).
  logic [7:0] m_isr;
  logic [2:0] m_rot;
  logic [2:0] m_level;
  logic       m_spur;
  int         m_edges;
  logic       m_prev;
  logic       m_valid = 1'b0;
  logic       e_int;
  logic [7:0] e_clr;
  logic       e_vd;
  logic [7:0] e_vo;

  function automatic logic [7:0] pick(input logic [7:0] isr, input logic [2:0] rot);
    for (int k = 1; k <= 8; k++) begin
      logic [2:0] l;
      l = 3'((int'(rot) + k) % 8);
      if (isr[l]) return 8'(1 << l);
    end
    return 8'd0;
  endfunction

  function automatic logic [2:0] lvl_of(input logic [7:0] oh);
    for (int i = 0; i < 8; i++) if (oh[i]) return 3'(i);
    return 3'd7;
  endfunction

  task automatic model_update();
    logic       fall;
    logic       rise;
    logic [7:0] isr_n;
    logic [7:0] clr;
    logic [2:0] rot_n;
    logic [2:0] lvl_n;
    logic [2:0] t;
    logic       spur_n;
    int         edges_n;
    if (reset) begin
      m_isr = 8'd0; m_rot = 3'd7; m_level = 3'd0; m_spur = 1'b0;
      m_edges = 0; m_prev = 1'b1; m_valid = 1'b1;
      e_int = 1'b0; e_clr = 8'd0; e_vd = 1'b0; e_vo = 8'd0;
      return;
    end
    fall = m_prev && !bus_if.inta_n;
    rise = !m_prev && bus_if.inta_n;
    isr_n = m_isr; rot_n = m_rot; lvl_n = m_level; spur_n = m_spur;
    edges_n = m_edges; clr = 8'd0;
    if (eoi_cmd && m_isr != 8'd0) begin
      t = eoi_specific ? eoi_level : lvl_of(pick(m_isr, m_rot));
      isr_n[t] = 1'b0;
      if (eoi_rotate) rot_n = t;
    end
    if (m_edges == 0 && fall) begin
      spur_n = (interrupt == 8'd0);
      lvl_n  = lvl_of(interrupt);
      if (!spur_n) begin
        isr_n[lvl_n] = 1'b1;
        clr = interrupt;
      end
      edges_n = 1;
    end else if (m_edges == 1 && rise) begin
      edges_n = 2;
    end else if (m_edges == 2 && fall) begin
      edges_n = 3;
    end else if (m_edges == 3 && rise) begin
      edges_n = 0;
      if (auto_eoi && !m_spur) begin
        isr_n[m_level] = 1'b0;
        if (auto_rotate) rot_n = m_level;
      end
    end
    e_int = (m_edges == 0) && !fall && (interrupt != 8'd0);
    e_clr = clr;
    e_vd  = (edges_n == 3);
    e_vo  = (edges_n == 3) ? {icw2_vector, lvl_n} : 8'd0;
    m_isr = isr_n; m_rot = rot_n; m_level = lvl_n; m_spur = spur_n;
    m_edges = edges_n; m_prev = bus_if.inta_n;
  endtask

  // Single compare process, half a cycle away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        chk("int_out", 8'(bus_if.int_out), 8'(e_int));
        chk("clear_req", clear_interrupt_request, e_clr);
        chk("isr", in_service_register, m_isr);
        chk("hlis", highest_level_in_service, pick(m_isr, m_rot));
        chk("rotate", 8'(priority_rotate), 8'(m_rot));
        chk("vec_drive", 8'(bus_if.vector_drive), 8'(e_vd));
        chk("vec_out", bus_if.vector_out, e_vo);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic eoi(input logic spec, input logic [2:0] lvl, input logic rot);
    eoi_cmd = 1'b1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
    step();
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
  endtask

  task automatic handshake(input logic [7:0] irq);
    interrupt = irq;
    step();
    bus_if.inta_n = 1'b0; step(); step();
    bus_if.inta_n = 1'b1; interrupt = 8'd0; step(); step();
    bus_if.inta_n = 1'b0; step(); step();
    bus_if.inta_n = 1'b1; step(); step();
  endtask

  initial begin
    reset = 1'b1; bus_if.inta_n = 1'b1; interrupt = 8'd0; icw2_vector = 5'b01000;
    auto_eoi = 1'b0; auto_rotate = 1'b0;
    eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; eoi_level = 3'd0;
    step(); step();
    chk("rst_isr", in_service_register, 8'h00);
    chk("rst_rot", 8'(priority_rotate), 8'h07);
    chk("rst_int", 8'(bus_if.int_out), 8'h00);
    chk("rst_vd", 8'(bus_if.vector_drive), 8'h00);
    reset = 1'b0; step();

    // IR3 basic two-pulse acknowledge
    interrupt = 8'h08; step();
    chk("ir3_int_rise", 8'(bus_if.int_out), 8'h01);
    chk("ir3_isr_pre", in_service_register, 8'h00);
    bus_if.inta_n = 1'b0; step();
    chk("ir3_clr", clear_interrupt_request, 8'h08);
    chk("ir3_isr", in_service_register, 8'h08);
    chk("ir3_int_low", 8'(bus_if.int_out), 8'h00);
    step();
    chk("ir3_clr_pulse", clear_interrupt_request, 8'h00);
    bus_if.inta_n = 1'b1; interrupt = 8'h00; step();
    chk("ir3_ack1_nodrive", 8'(bus_if.vector_drive), 8'h00);
    step();
    bus_if.inta_n = 1'b0; step();
    chk("ir3_vd", 8'(bus_if.vector_drive), 8'h01);
    chk("ir3_vec", bus_if.vector_out, 8'h43);
    step();
    bus_if.inta_n = 1'b1; step();
    chk("ir3_vd_drop", 8'(bus_if.vector_drive), 8'h00);
    chk("ir3_isr_hold", in_service_register, 8'h08);
    eoi(1'b0, 3'd0, 1'b0);
    chk("ir3_eoi", in_service_register, 8'h00);

    // AEOI with rotation on IR5
    auto_eoi = 1'b1; auto_rotate = 1'b1;
    handshake(8'h20);
    chk("aeoi_isr", in_service_register, 8'h00);
    chk("aeoi_rot", 8'(priority_rotate), 8'h05);
    auto_eoi = 1'b0; auto_rotate = 1'b0;
    handshake(8'h01); handshake(8'h40);
    chk("rot5_isr", in_service_register, 8'h41);
    chk("rot5_hlis", highest_level_in_service, 8'h40);
    eoi(1'b1, 3'd7, 1'b1);
    chk("spec_rot7", 8'(priority_rotate), 8'h07);
    eoi(1'b0, 3'd0, 1'b0);
    chk("ns_eoi_bit0", in_service_register, 8'h40);
    eoi(1'b0, 3'd0, 1'b0);
    chk("ns_eoi_bit6", in_service_register, 8'h00);

    // ISR 8'h24, rotate 7: non-specific then specific EOI
    handshake(8'h04); handshake(8'h20);
    chk("isr24", in_service_register, 8'h24);
    eoi(1'b0, 3'd0, 1'b0);
    chk("isr24_ns", in_service_register, 8'h20);
    eoi(1'b1, 3'd5, 1'b0);
    chk("isr24_spec5", in_service_register, 8'h00);

    // Spurious: request withdrawn before INTA
    interrupt = 8'h10; step();
    chk("spur_int", 8'(bus_if.int_out), 8'h01);
    interrupt = 8'h00; step();
    bus_if.inta_n = 1'b0; step();
    chk("spur_clr", clear_interrupt_request, 8'h00);
    chk("spur_isr", in_service_register, 8'h00);
    step();
    bus_if.inta_n = 1'b1; step(); step();
    bus_if.inta_n = 1'b0; step();
    chk("spur_vd", 8'(bus_if.vector_drive), 8'h01);
    chk("spur_vec", bus_if.vector_out, 8'h47);
    step();
    bus_if.inta_n = 1'b1; step(); step();

    // Reset during WAIT2
    interrupt = 8'h02; step();
    bus_if.inta_n = 1'b0; step(); step();
    bus_if.inta_n = 1'b1; interrupt = 8'h00; step();
    eoi(1'b1, 3'd3, 1'b1);
    chk("wait2_rot3", 8'(priority_rotate), 8'h03);
    chk("wait2_isr", in_service_register, 8'h02);
    reset = 1'b1; step();
    chk("mid_rst_isr", in_service_register, 8'h00);
    chk("mid_rst_rot", 8'(priority_rotate), 8'h07);
    chk("mid_rst_vd", 8'(bus_if.vector_drive), 8'h00);
    chk("mid_rst_vec", bus_if.vector_out, 8'h00);
    chk("mid_rst_clr", clear_interrupt_request, 8'h00);
    reset = 1'b0; step();
    handshake(8'h80);
    chk("post_rst_isr", in_service_register, 8'h80);
    eoi(1'b0, 3'd0, 1'b0);

    // Specific EOI on level 2 coincident with first fall on IR2
    handshake(8'h04);
    interrupt = 8'h04; step();
    eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2; bus_if.inta_n = 1'b0;
    step();
    eoi_cmd = 1'b0; eoi_specific = 1'b0;
    chk("coinc_isr", in_service_register, 8'h04);
    step();
    bus_if.inta_n = 1'b1; interrupt = 8'h00; step(); step();
    bus_if.inta_n = 1'b0; step(); step();
    bus_if.inta_n = 1'b1; step(); step();
    eoi(1'b0, 3'd0, 1'b0);
    chk("coinc_clean", in_service_register, 8'h00);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0)
        interrupt = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) bus_if.inta_n = ~bus_if.inta_n;
      eoi_cmd      = ($urandom_range(0, 9) == 0);
      eoi_specific = 1'($urandom_range(0, 1));
      eoi_rotate   = 1'($urandom_range(0, 1));
      eoi_level    = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 63) == 0) begin
        auto_eoi    = 1'($urandom_range(0, 1));
        auto_rotate = 1'($urandom_range(0, 1));
        icw2_vector = 5'($urandom_range(0, 31));
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; eoi_cmd = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
